// File: rtl/led_message_scroller_pkg.sv
// Shared definitions for the LED message scroller.
//   - Character codes that have a fixed meaning (dash, blank).
//   - Message length and number of display digits.
//   - FSM state encoding.
//   - window_index(): which message entry a given digit shows.
package led_message_scroller_pkg;

  localparam int DIGITS  = 4;   // physical seven-segment digits
  localparam int MSG_LEN = 16;  // characters held in the message register

  localparam logic [3:0] CH_DASH  = 4'd10;
  localparam logic [3:0] CH_BLANK = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Digit k shows message entry (ptr + DIGITS-1 - k) mod 16, so the leftmost
  // digit (k = DIGITS-1) shows the entry at ptr. 4-bit arithmetic wraps for us.
  function automatic logic [3:0] window_index(input logic [3:0] ptr,
                                              input logic [1:0] digit);
    return ptr + (4'(DIGITS - 1) - {2'b00, digit});
  endfunction

endpackage

// File: rtl/led_message_scroller_decoder.sv
// LEDDecoder: 4-bit character code to seven-segment pattern.
// Ports:
//   char_in  [3:0]  character code (0-9 digits, 10 dash, 11 blank, 12-15 'F')
//   seg_out  [6:0]  segments {A,B,C,D,E,F,G}, active-high
// Purely combinational; the scroller registers its output.
module LEDDecoder
  import led_message_scroller_pkg::*;
(
  input  logic [3:0] char_in,
  output logic [6:0] seg_out
);

  always_comb begin
    case (char_in)
      4'd0:     seg_out = 7'b1111110;
      4'd1:     seg_out = 7'b0110000;
      4'd2:     seg_out = 7'b1101101;
      4'd3:     seg_out = 7'b1111001;
      4'd4:     seg_out = 7'b0110011;
      4'd5:     seg_out = 7'b1011011;
      4'd6:     seg_out = 7'b1011111;
      4'd7:     seg_out = 7'b1110000;
      4'd8:     seg_out = 7'b1111111;
      4'd9:     seg_out = 7'b1111011;
      CH_DASH:  seg_out = 7'b0000001;
      CH_BLANK: seg_out = 7'b0000000;
      default:  seg_out = 7'b1000111;  // codes 12-15 all render as 'F'
    endcase
  end

endmodule

// File: rtl/led_message_scroller.sv
// led_message_scroller: scrolls a 16-character message across a 4-digit,
// time-multiplexed seven-segment display.
//
// Parameters:
//   REFRESH_DIV  clk cycles each digit is lit before moving on (>= 2)
//   SCROLL_DIV   clk cycles per scroll step while running (>= 2)
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   load         pulse: capture msg_in, rewind ptr, clear scroll counter
//   msg_in[63:0] char i = msg_in[4i+3:4i]
//   start        pulse: begin/resume scrolling (restart from 0 when holding)
//   stop         pulse: freeze scrolling (wins over start)
//   an[3:0]      digit enables, active-low, an[3] = leftmost
//   seg[6:0]     segments {A..G}, active-high
//   busy         high while scrolling (RUN)
//   wrap         one-cycle pulse when a scroll step returns ptr to 0
//
// Build option MSG_LOOP_EN:
//   defined   - scrolling loops forever, ptr wraps 15->0 and pulses wrap.
//   undefined - the step that brings ptr to 12 parks the FSM in HOLD
//               (last four characters on screen); wrap never pulses.
module led_message_scroller
  import led_message_scroller_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int SCROLL_DIV  = 25000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] msg_in,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        busy,
  output logic        wrap
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

`ifndef MSG_LOOP_EN
  // Window position at which the last character sits in the rightmost digit.
  localparam logic [3:0] HOLD_PTR = 4'(MSG_LEN - DIGITS);
`endif

  state_t                     state_q, state_d;
  logic [3:0]                 ptr_q, ptr_d;
  logic [SW-1:0]              scnt_q, scnt_d;
  logic [RW-1:0]              rcnt_q, rcnt_d;
  logic [1:0]                 digit_q, digit_d;
  logic [MSG_LEN-1:0][3:0]    msg_q, msg_d;
  logic [3:0]                 an_q, an_d;
  logic [6:0]                 seg_q, seg_d;
  logic                       busy_q, busy_d;
  logic                       wrap_q, wrap_d;

  logic                       step;
  logic [3:0]                 char_sel;

  // ---------------------------------------------------------------------
  // Display scan: one shared decoder, fed with whichever character the
  // currently selected digit should show.
  // ---------------------------------------------------------------------
  assign char_sel = msg_q[window_index(ptr_q, digit_q)];

  LEDDecoder u_decoder (
    .char_in (char_sel),
    .seg_out (seg_d)
  );

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_an
    assign an_d[gi] = (digit_q != 2'(gi));
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    scnt_d  = scnt_q;
    msg_d   = msg_q;
    wrap_d  = 1'b0;
    step    = 1'b0;

    // Refresh scan runs regardless of FSM state.
    if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
      rcnt_d  = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      rcnt_d  = rcnt_q + 1'b1;
      digit_d = digit_q;
    end

    // Load outranks scrolling; a stop arriving in RUN freezes the counter
    // on that very cycle so a later start resumes from the same phase.
    if (load) begin
      msg_d  = msg_in;
      ptr_d  = '0;
      scnt_d = '0;
    end else if (state_q == ST_RUN && !stop) begin
      if (scnt_q == SW'(SCROLL_DIV - 1)) begin
        scnt_d = '0;
        ptr_d  = ptr_q + 4'd1;
        step   = 1'b1;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end

`ifdef MSG_LOOP_EN
    wrap_d = step && (ptr_q == 4'hF);
`else
    if (step && ptr_d == HOLD_PTR) begin
      state_d = ST_HOLD;
    end
`endif

    // Command handling; stop always beats start.
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
          ptr_d   = '0;
          scnt_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      scnt_q  <= '0;
      rcnt_q  <= '0;
      digit_q <= '0;
      msg_q   <= {MSG_LEN{CH_BLANK}};
      an_q    <= 4'b1111;
      seg_q   <= 7'b0000000;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      scnt_q  <= scnt_d;
      rcnt_q  <= rcnt_d;
      digit_q <= digit_d;
      msg_q   <= msg_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign busy = busy_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_led_message_scroller.sv
// Self-checking bench for led_message_scroller (REFRESH_DIV=2, SCROLL_DIV=16).
// A cycle-level reference model predicts an/seg/busy/wrap after every edge;
// directed scenarios add hand-computed checks. Honours MSG_LOOP_EN.
`timescale 1ns/1ps
module tb_led_message_scroller;

  localparam int REFRESH_DIV = 2;
  localparam int SCROLL_DIV  = 16;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [63:0] msg_in;
  logic        start;
  logic        stop;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        busy;
  logic        wrap;

  led_message_scroller #(
    .REFRESH_DIV (REFRESH_DIV),
    .SCROLL_DIV  (SCROLL_DIV)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .msg_in (msg_in),
    .start  (start),
    .stop   (stop),
    .an     (an),
    .seg    (seg),
    .busy   (busy),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [6:0] seg;
  } dec_vec_t;

  dec_vec_t   dec_tab [16];
  logic [6:0] font [16];
  logic [3:0] an_seq [8];

  int checks = 0;
  int errors = 0;
  int fail_prints = 0;
  int cyc = 0;

  // reference model state
  int m_state, m_ptr, m_phase, m_scan;
  int m_msg [16];
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_busy, exp_wrap;

  logic [63:0] vm;
  int start_cyc, wraps, wrap_at, drops;

  task automatic report(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s got %h want %h at cycle %0d", name, act, req, cyc);
      end
    end
  endtask

  // Advance the model across one rising edge given the inputs seen there.
  task automatic model_edge(input logic r, input logic l, input logic s,
                            input logic p, input logic [63:0] m);
    int old_state, digit;
    if (r) begin
      m_state = M_IDLE; m_ptr = 0; m_phase = 0; m_scan = 0;
      for (int i = 0; i < 16; i++) m_msg[i] = 11;
      exp_an = 4'hF; exp_seg = 7'd0; exp_busy = 1'b0; exp_wrap = 1'b0;
    end else begin
      // display registers what was selected before this edge
      digit = (m_scan / REFRESH_DIV) % 4;
      exp_an = 4'hF;
      exp_an[digit] = 1'b0;
      exp_seg = font[m_msg[(m_ptr + 3 - digit) % 16]];
      m_scan++;
      exp_wrap = 1'b0;
      old_state = m_state;
      if (l) begin
        for (int i = 0; i < 16; i++) m_msg[i] = int'(m[4*i +: 4]);
        m_ptr = 0;
        m_phase = 0;
      end else if (old_state == M_RUN && !p) begin
        m_phase++;
        if (m_phase == SCROLL_DIV) begin
          m_phase = 0;
          m_ptr = (m_ptr + 1) % 16;
`ifdef MSG_LOOP_EN
          if (m_ptr == 0) exp_wrap = 1'b1;
`else
          if (m_ptr == 12) m_state = M_HOLD;
`endif
        end
      end
      if (old_state == M_IDLE && s && !p) m_state = M_RUN;
      else if (old_state == M_RUN && p) m_state = M_IDLE;
      else if (old_state == M_HOLD) begin
        if (p) m_state = M_IDLE;
        else if (s) begin
          m_state = M_RUN; m_ptr = 0; m_phase = 0;
        end
      end
      exp_busy = (m_state == M_RUN);
    end
  endtask

  task automatic cycle(input logic r, input logic l, input logic s,
                       input logic p, input logic [63:0] m);
    reset = r; load = l; start = s; stop = p; msg_in = m;
    @(posedge clk);
    model_edge(r, l, s, p, m);
    cyc++;
    #1;
    report("model_outputs", 32'({an, seg, busy, wrap}),
           32'({exp_an, exp_seg, exp_busy, exp_wrap}));
    reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, msg_in);
  endtask

  // At least one cycle, then until an matches or the budget runs out.
  task automatic wait_an(input logic [3:0] target, input int budget, input string name);
    int n;
    n = 0;
    do begin
      idle();
      n++;
    end while (an !== target && n < budget);
    report({name, "_wait"}, 32'(an), 32'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_tab[0]  = '{4'd0,  7'b1111110};
    dec_tab[1]  = '{4'd1,  7'b0110000};
    dec_tab[2]  = '{4'd2,  7'b1101101};
    dec_tab[3]  = '{4'd3,  7'b1111001};
    dec_tab[4]  = '{4'd4,  7'b0110011};
    dec_tab[5]  = '{4'd5,  7'b1011011};
    dec_tab[6]  = '{4'd6,  7'b1011111};
    dec_tab[7]  = '{4'd7,  7'b1110000};
    dec_tab[8]  = '{4'd8,  7'b1111111};
    dec_tab[9]  = '{4'd9,  7'b1111011};
    dec_tab[10] = '{4'd10, 7'b0000001};
    dec_tab[11] = '{4'd11, 7'b0000000};
    dec_tab[12] = '{4'd12, 7'b1000111};
    dec_tab[13] = '{4'd13, 7'b1000111};
    dec_tab[14] = '{4'd14, 7'b1000111};
    dec_tab[15] = '{4'd15, 7'b1000111};
    for (int i = 0; i < 16; i++) font[dec_tab[i].code] = dec_tab[i].seg;

    an_seq[0] = 4'b1110; an_seq[1] = 4'b1110;
    an_seq[2] = 4'b1101; an_seq[3] = 4'b1101;
    an_seq[4] = 4'b1011; an_seq[5] = 4'b1011;
    an_seq[6] = 4'b0111; an_seq[7] = 4'b0111;

    reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0; msg_in = 64'd0;

    // ---- reset state and release scan ----
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    report("reset_an",   32'(an),   32'(4'b1111));
    report("reset_seg",  32'(seg),  32'(7'd0));
    report("reset_busy", 32'(busy), 32'(1'b0));
    report("reset_wrap", 32'(wrap), 32'(1'b0));
    for (int i = 0; i < 8; i++) begin
      idle();
      report("release_an",  32'(an),  32'(an_seq[i]));
      report("release_seg", 32'(seg), 32'(7'd0));
    end
    $display("scenario reset_release an=%b seg=%b", an, seg);

    // ---- decoder table: each code on the leftmost digit ----
    for (int i = 0; i < 16; i++) begin
      vm = {60'hBBBBBBBBBBBBBBB, dec_tab[i].code};
      cycle(1'b0, 1'b1, 1'b0, 1'b0, vm);
      wait_an(4'b0111, 10, "dec");
      report("dec_seg", 32'(seg), 32'(dec_tab[i].seg));
      $display("vec %0d code %0d seg %b", i, dec_tab[i].code, seg);
    end

    // ---- load and start ----
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'hBBBB_9876_5432_10BA);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 64'hBBBB_9876_5432_10BA);
    start_cyc = cyc;
    report("ls_busy", 32'(busy), 32'(1'b1));
    wait_an(4'b0111, 10, "ls_left");
    report("ls_left_dash", 32'(seg), 32'(7'b0000001));
    wait_an(4'b1110, 10, "ls_d0");
    report("ls_d0_one", 32'(seg), 32'(7'b0110000));
    while (cyc - start_cyc < 16) idle();
    wait_an(4'b0111, 10, "ls_ptr1_left");
    report("ls_ptr1_left_blank", 32'(seg), 32'(7'b0000000));
    wait_an(4'b1110, 10, "ls_ptr1_d0");
    report("ls_ptr1_d0_two", 32'(seg), 32'(7'b1101101));
    $display("scenario load_start busy=%b seg=%b", busy, seg);

    // ---- stop five cycles into a period, resume later ----
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'hFEDC_BA98_7654_3210);
    repeat (5) idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, msg_in);
    report("sr_stopped", 32'(busy), 32'(1'b0));
    repeat (40) idle();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, msg_in);
    report("sr_resumed", 32'(busy), 32'(1'b1));
    repeat (40) idle();
    $display("scenario stop_resume busy=%b", busy);

    // ---- wrap / hold ----
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'hFEDC_BA98_7654_3210);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, msg_in);
`ifdef MSG_LOOP_EN
    wraps = 0; wrap_at = 0; drops = 0;
    for (int i = 1; i <= 256; i++) begin
      idle();
      if (wrap) begin wraps++; wrap_at = i; end
      if (!busy) drops++;
    end
    report("wrap_count", 32'(wraps), 32'(1));
    report("wrap_cycle", 32'(wrap_at), 32'(256));
    report("wrap_busy_drops", 32'(drops), 32'(0));
    $display("scenario wrap wraps=%0d at=%0d", wraps, wrap_at);
`else
    wraps = 0;
    for (int i = 1; i <= 191; i++) begin
      idle();
      if (wrap) wraps++;
    end
    report("hold_pre_busy", 32'(busy), 32'(1'b1));
    idle();
    report("hold_busy", 32'(busy), 32'(1'b0));
    for (int i = 0; i < 40; i++) begin
      idle();
      if (wrap) wraps++;
    end
    report("hold_stays", 32'(busy), 32'(1'b0));
    report("hold_no_wrap", 32'(wraps), 32'(0));
    cycle(1'b0, 1'b0, 1'b1, 1'b0, msg_in);
    report("hold_restart_busy", 32'(busy), 32'(1'b1));
    wait_an(4'b0111, 10, "hold_restart");
    report("hold_restart_ptr0", 32'(seg), 32'(7'b1111110));
    $display("scenario hold busy=%b seg=%b", busy, seg);
`endif

    // ---- collisions ----
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, msg_in);
    report("coll_start_stop", 32'(busy), 32'(1'b0));
    repeat (20) idle();
    report("coll_still_idle", 32'(busy), 32'(1'b0));
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 64'hFEDC_BA98_7654_3210);
    report("coll_load_start", 32'(busy), 32'(1'b1));
    repeat (115) idle();  // seven steps: ptr = 7
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_0008);
    report("coll_load_run_busy", 32'(busy), 32'(1'b1));
    wait_an(4'b0111, 8, "coll_new");
    report("coll_new_char", 32'(seg), 32'(7'b1111111));
    $display("scenario collision busy=%b seg=%b", busy, seg);

    // ---- randomized traffic against the model ----
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 599) == 0), ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 49) == 0),
            {$urandom, $urandom});
    end
    $display("scenario random cycles=%0d", cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_message_scroller.md
LED_MESSAGE_SCROLLER -- requirements
Module: led_message_scroller

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clk cycles per digit slot (minimum 2).
REQ-002 SHALL have parameter SCROLL_DIV, default 25000000: clk cycles per scroll step (minimum 2).
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load  input  1  single-cycle pulse: capture msg_in.
REQ-007 msg_in  input  64  16 chars of 4 bits each; char i = msg_in[4i+3:4i]; codes: 0-9 digits, 10 dash, 11 blank, 12-15 F.
REQ-008 start  input  1  single-cycle pulse: begin or resume scrolling.
REQ-009 stop  input  1  single-cycle pulse: freeze scrolling.
REQ-010 an  output  4  digit enables, active-low; an[3] = leftmost digit.
REQ-011 seg  output  7  segments {A,B,C,D,E,F,G}, active-high.
REQ-012 busy  output  1  high in RUN.
REQ-013 wrap  output  1  one-cycle pulse on the scroll step that returns ptr to 0.

Function
REQ-014 SHALL hold a 16-entry message register and a 4-bit window pointer ptr.
REQ-015 Digit k SHALL show char (ptr+3-k) mod 16: an[3] shows ptr; wraps modulo 16.
REQ-016 Refresh counter SHALL count 0..REFRESH_DIV-1 in all states; at terminal count, digit index advances 0->1->2->3->0.
REQ-017 an and seg SHALL be registered together, one cycle after the digit index changes; exactly one an bit is low outside reset.
REQ-018 FSM states SHALL be IDLE, RUN, HOLD; reset enters IDLE.
REQ-019 IDLE: start -> RUN; scroll counter frozen; display scans the frozen window.
REQ-020 RUN: scroll counter counts 0..SCROLL_DIV-1; at terminal count ptr increments and the counter clears.
REQ-021 RUN: stop -> IDLE with ptr and scroll counter frozen; a later start resumes with no reset of either.
REQ-022 HOLD: start -> RUN with ptr=0 and scroll counter=0; stop -> IDLE.
REQ-023 load in any state SHALL capture msg_in, set ptr=0 and clear the scroll counter; the state is unchanged.
REQ-024 Simultaneous start and stop: stop wins.
REQ-025 Simultaneous load and start: load is applied, then the start transition is taken in the same cycle.
REQ-026 wrap SHALL pulse on the same cycle ptr goes 15->0; busy SHALL equal (state==RUN).

Reset
REQ-027 On reset, the block SHALL set:
- state=IDLE, ptr=0, digit index=0.
- refresh and scroll counters=0.
- all message entries=11 (blank).
- an=4'b1111, seg=7'b0000000, busy=0, wrap=0.
REQ-028 Reset asserted mid-scroll SHALL override all other inputs in that cycle.

Configuration
REQ-029 Macro MSG_LOOP_EN defined: in RUN, ptr wraps 15->0 and scrolling continues indefinitely.
REQ-030 Macro MSG_LOOP_EN undefined: when a scroll step brings ptr to 12, the FSM enters HOLD, ptr stays 12, and wrap never asserts.

Structure
REQ-031 A shared package or header SHALL hold:
- char code constants CH_DASH=10 and CH_BLANK=11.
- FSM state encodings.
- the digit count, 4.
REQ-032 The block SHALL instantiate the team's existing 4-bit char-to-segment decoder, LEDDecoder, once, time-multiplexed across the digits; no other sub-modules.

Verification
REQ-033 Test parameters SHALL be REFRESH_DIV=2 and SCROLL_DIV=16.
REQ-034 Reset release scenario: release reset with no other stimulus -> seg=0 before the first scan, then blank pattern 0000000 on all four digits; an cycles 1110, 1101, 1011, 0111 every 2 cycles.
REQ-035 Load and start scenario: load msg_in=64'hBBBB_9876_5432_10BA, then start -> leftmost digit shows 10 (dash, 0000001) and digit0 shows 1 (0110000); after 16 cycles ptr=1.
REQ-036 Stop/resume scenario: stop 5 cycles into a scroll period, wait 40 cycles, then start -> ptr unchanged; the next step occurs 11 cycles after start.
REQ-037 Wrap scenario (MSG_LOOP_EN defined): run 256 cycles from ptr=0 -> wrap pulses once at the 15->0 step; busy stays 1.
REQ-038 Hold scenario (MSG_LOOP_EN undefined): run from ptr=0 -> HOLD after 192 cycles with ptr=12 and busy=0; start -> ptr=0, RUN.
REQ-039 Collision scenario: start and stop in the same cycle in IDLE -> stays IDLE; load during RUN at ptr=7 -> ptr=0 and the new chars appear within 8 cycles.
